// File: rtl/float7_frame_accumulator.sv
// float7_frame_accumulator
// Decodes 7-bit float codes (4-bit mantissa M, 3-bit exponent E) from the
// integer-to-float encoder back to 11-bit integers, accumulates them over a
// frame and presents the saturated frame sum on a registered valid/ready port.
module float7_frame_accumulator #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = 16,
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_m,
    input  logic [2:0]       in_e,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int unsigned VAL_W = 11;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [VAL_W-1:0] value;
    logic [SUM_W-1:0] sum_wide;
    logic             overflow;
    logic             beat;
    logic             frame_end;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    // E==0 is the linear region; otherwise the implicit leading one is restored
    function automatic logic [VAL_W-1:0] decode(input logic [3:0] m, input logic [2:0] e);
        logic [VAL_W-1:0] v;
        if (e == 3'd0) begin
            v = VAL_W'(m);
        end else begin
            v = VAL_W'({1'b1, m}) << (e - 3'd1);
        end
        return v;
    endfunction

    // Decode, widened add with clamp, and frame-end detection
    always_comb begin
        value     = decode(in_m, in_e);
        beat      = in_valid && (state == ACC);
        sum_wide  = SUM_W'(acc) + SUM_W'(value);
        overflow  = sum_wide[ACC_W];
        acc_next  = acc;
        cnt_next  = cnt;
        sat_next  = sat;
        if (beat) begin
            acc_next = overflow ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            cnt_next = cnt + CNT_W'(1);
            sat_next = sat | overflow;
        end
        // A lone flush on an empty frame produces nothing
        frame_end = (state == ACC) &&
                    ((beat && (cnt_next == LAST_CNT)) || (flush && (cnt_next != '0)));
    end

    // Frame FSM: accumulate in ACC, present the result in HOLD until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    sat <= sat_next;
                    if (frame_end) begin
                        out_sum   <= acc_next;
                        out_count <= cnt_next;
                        out_sat   <= sat_next;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Result fields stay put after the handshake until the next frame
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state     <= ACC;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float7_frame_accumulator.sv
// Scoreboard bench for float7_frame_accumulator: three instances (defaults,
// FRAME_LEN=1, ACC_W=14) driven with directed vectors; monitors pop expected
// frame results whenever an output handshake is seen.
module tb_float7_frame_accumulator;

    typedef struct {
        int sum;
        int count;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qd[$];
    exp_t qf[$];
    exp_t qs[$];
    exp_t ed;
    exp_t ef;
    exp_t es;

    // default instance
    logic        d_in_valid = 1'b0, d_flush = 1'b0, d_out_ready = 1'b1;
    logic [3:0]  d_in_m = '0;
    logic [2:0]  d_in_e = '0;
    logic        d_in_ready, d_out_valid, d_out_sat;
    logic [15:0] d_out_sum;
    logic [4:0]  d_out_count;

    // FRAME_LEN=1 instance
    logic        f_in_valid = 1'b0, f_flush = 1'b0, f_out_ready = 1'b1;
    logic [3:0]  f_in_m = '0;
    logic [2:0]  f_in_e = '0;
    logic        f_in_ready, f_out_valid, f_out_sat;
    logic [15:0] f_out_sum;
    logic [0:0]  f_out_count;

    // ACC_W=14 instance
    logic        s_in_valid = 1'b0, s_flush = 1'b0, s_out_ready = 1'b1;
    logic [3:0]  s_in_m = '0;
    logic [2:0]  s_in_e = '0;
    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [13:0] s_out_sum;
    logic [4:0]  s_out_count;

    float7_frame_accumulator u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_m(d_in_m), .in_e(d_in_e), .flush(d_flush), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_sum(d_out_sum), .out_count(d_out_count),
        .out_sat(d_out_sat)
    );

    float7_frame_accumulator #(.FRAME_LEN(1)) u_f (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_m(f_in_m), .in_e(f_in_e), .flush(f_flush), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_sum(f_out_sum), .out_count(f_out_count),
        .out_sat(f_out_sat)
    );

    float7_frame_accumulator #(.ACC_W(14)) u_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_m(s_in_m), .in_e(s_in_e), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
        .out_sat(s_out_sat)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int inst, input int sum, input int count, input int sat);
        exp_t e;
        e.sum = sum; e.count = count; e.sat = sat;
        case (inst)
            0: qd.push_back(e);
            1: qf.push_back(e);
            default: qs.push_back(e);
        endcase
    endtask

    task automatic drv(input int inst, input logic v, input logic [3:0] m,
                       input logic [2:0] e, input logic fl);
        case (inst)
            0: begin d_in_valid = v; d_in_m = m; d_in_e = e; d_flush = fl; end
            1: begin f_in_valid = v; f_in_m = m; f_in_e = e; f_flush = fl; end
            default: begin s_in_valid = v; s_in_m = m; s_in_e = e; s_flush = fl; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int inst);
        drv(inst, 1'b0, 4'd0, 3'd0, 1'b0);
    endtask

    // Monitors: compare each accepted result against the oldest expectation
    always @(negedge clk) begin
        if (d_out_valid && d_out_ready) begin
            if (qd.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected_result actual_sum=%0d required=none", d_out_sum);
            end else begin
                ed = qd.pop_front();
                check("d_sum", int'(d_out_sum), ed.sum);
                check("d_count", int'(d_out_count), ed.count);
                check("d_sat", int'(d_out_sat), ed.sat);
            end
        end
    end

    always @(negedge clk) begin
        if (f_out_valid && f_out_ready) begin
            if (qf.size() == 0) begin
                checks++; errors++;
                $display("FAIL f_unexpected_result actual_sum=%0d required=none", f_out_sum);
            end else begin
                ef = qf.pop_front();
                check("f_sum", int'(f_out_sum), ef.sum);
                check("f_count", int'(f_out_count), ef.count);
                check("f_sat", int'(f_out_sat), ef.sat);
            end
        end
    end

    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            if (qs.size() == 0) begin
                checks++; errors++;
                $display("FAIL s_unexpected_result actual_sum=%0d required=none", s_out_sum);
            end else begin
                es = qs.pop_front();
                check("s_sum", int'(s_out_sum), es.sum);
                check("s_count", int'(s_out_count), es.count);
                check("s_sat", int'(s_out_sat), es.sat);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", int'(d_out_valid), 0);
        check("rst_out_sum", int'(d_out_sum), 0);
        check("rst_out_count", int'(d_out_count), 0);
        check("rst_out_sat", int'(d_out_sat), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", int'(d_in_ready), 1);
        check("rst_f_in_ready", int'(f_in_ready), 1);

        // Decode sweep on FRAME_LEN=1
        push(1, 5, 1, 0);    drv(1, 1'b1, 4'd5, 3'd0, 1'b0);  tick(); idle(1); tick(); tick();
        push(1, 16, 1, 0);   drv(1, 1'b1, 4'd0, 3'd1, 1'b0);  tick(); idle(1); tick(); tick();
        push(1, 104, 1, 0);  drv(1, 1'b1, 4'd10, 3'd3, 1'b0); tick(); idle(1); tick(); tick();
        push(1, 1984, 1, 0); drv(1, 1'b1, 4'd15, 3'd7, 1'b0); tick(); idle(1); tick(); tick();

        // Full frame at defaults, with result latency
        push(0, 31744, 16, 0);
        for (int i = 0; i < 16; i++) begin
            drv(0, 1'b1, 4'd15, 3'd7, 1'b0);
            tick();
            if (i == 14) check("full_valid_before_last", int'(d_out_valid), 0);
        end
        check("full_valid_after_last", int'(d_out_valid), 1);
        idle(0); tick(); tick();

        // Saturation at ACC_W=14, then a clean frame
        push(2, 16383, 16, 1);
        for (int i = 0; i < 16; i++) begin
            drv(2, 1'b1, 4'd15, 3'd7, 1'b0);
            tick();
        end
        idle(2); tick(); tick();
        push(2, 2, 2, 0);
        drv(2, 1'b1, 4'd1, 3'd0, 1'b0); tick();
        drv(2, 1'b1, 4'd1, 3'd0, 1'b1); tick();
        idle(2); tick(); tick();

        // Flush together with the third beat
        push(0, 125, 3, 0);
        drv(0, 1'b1, 4'd5, 3'd0, 1'b0);  tick();
        drv(0, 1'b1, 4'd0, 3'd1, 1'b0);  tick();
        drv(0, 1'b1, 4'd10, 3'd3, 1'b1); tick();
        idle(0); tick(); tick();

        // Flush on an empty frame produces nothing
        drv(0, 1'b0, 4'd0, 3'd0, 1'b1); tick();
        idle(0);
        for (int i = 0; i < 4; i++) tick();
        check("empty_flush_no_valid", int'(d_out_valid), 0);

        // Backpressure: result held, input stalled, beats not consumed
        push(0, 5, 2, 0);
        drv(0, 1'b1, 4'd2, 3'd0, 1'b0); tick();
        drv(0, 1'b1, 4'd3, 3'd0, 1'b1);
        d_out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drv(0, 1'b1, 4'd15, 3'd7, 1'b1);
            check("bp_out_valid", int'(d_out_valid), 1);
            check("bp_in_ready", int'(d_in_ready), 0);
            check("bp_out_sum", int'(d_out_sum), 5);
            tick();
        end
        idle(0);
        d_out_ready = 1'b1;
        tick();
        check("bp_in_ready_after", int'(d_in_ready), 1);
        check("bp_valid_after", int'(d_out_valid), 0);
        check("bp_sum_kept", int'(d_out_sum), 5);
        push(0, 1, 1, 0);
        drv(0, 1'b1, 4'd1, 3'd0, 1'b1); tick();
        idle(0); tick(); tick();

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) begin
            drv(0, 1'b1, 4'd15, 3'd7, 1'b0);
            tick();
        end
        idle(0);
        rst = 1'b1; #2; rst = 1'b0;
        check("midrst_out_valid", int'(d_out_valid), 0);
        tick();
        push(0, 16, 16, 0);
        for (int i = 0; i < 16; i++) begin
            drv(0, 1'b1, 4'd1, 3'd0, 1'b0);
            tick();
        end
        idle(0); tick(); tick();

        // Reset during HOLD drops out_valid asynchronously
        d_out_ready = 1'b0;
        drv(0, 1'b1, 4'd1, 3'd0, 1'b1); tick();
        idle(0);
        check("hold_valid_pre_rst", int'(d_out_valid), 1);
        rst = 1'b1; #1;
        check("hold_valid_async_rst", int'(d_out_valid), 0);
        check("hold_sum_async_rst", int'(d_out_sum), 0);
        #1 rst = 1'b0;
        d_out_ready = 1'b1;
        tick(); tick(); tick();

        // Every expected result consumed, none left over
        check("qd_empty", qd.size(), 0);
        check("qf_empty", qf.size(), 0);
        check("qs_empty", qs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float7_frame_accumulator.md
Name: float7_frame_accumulator

Overview:
- Streaming stage directly downstream of the 11-bit integer-to-float encoder.
- Takes its 7-bit float codes (4-bit mantissa M, 3-bit exponent E) on a valid/ready stream and decodes each code back to an 11-bit integer magnitude.
- Accumulates the decoded values over a frame of FRAME_LEN samples, or fewer if the frame is ended early by flush.
- Presents the saturated frame sum on a registered valid/ready output for the next stage.

Parameters:
- FRAME_LEN, 16: samples per frame; legal range 1..1024.
- ACC_W, 16: accumulator and out_sum width in bits; minimum 11.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept a code.
- in_m  in  4  mantissa M[3:0].
- in_e  in  3  exponent E[2:0].
- flush  in  1  end the current frame early; sampled only while in_ready=1.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  saturated frame sum.
- out_count  out  $clog2(FRAME_LEN+1)  number of samples in the frame.
- out_sat  out  1  saturation occurred during the frame.

Behaviour:
- Clock and reset
  - One clock domain (clk).
  - rst is asynchronous and active-high.
  - Reset values: state=ACC, acc=0, cnt=0, sat=0, out_valid=0, out_sum=0, out_count=0, out_sat=0. in_ready is 1 after reset release.
- Decode (combinational, 11-bit unsigned result)
  - E==0: value = M, range 0..15.
  - E>0: value = {1'b1, M} << (E-1).
  - Maximum value: E=7, M=15 gives 31<<6 = 1984.
- States: ACC and HOLD.
- ACC state
  - in_ready=1, out_valid=0.
  - Beat: in_valid & in_ready.
  - On a beat: acc_next = min(acc + value, 2^ACC_W - 1); cnt += 1.
  - sat is set if the unclamped sum exceeds 2^ACC_W - 1. It is sticky until the frame completes.
- Frame end
  - Ends on the beat that makes cnt_next == FRAME_LEN.
  - Also ends on any ACC cycle with flush=1 and cnt_next > 0.
  - If flush and a beat occur in the same cycle, the beat is included in the frame.
  - flush=1 with cnt=0 and no beat is ignored; no empty frames are produced.
- On frame end
  - out_sum, out_count and out_sat are loaded from acc_next, cnt_next and sat_next.
  - Next state is HOLD.
  - Latency: out_valid rises the cycle after the final beat or flush.
- HOLD state
  - in_ready=0, out_valid=1.
  - out_sum, out_count and out_sat are held stable while out_ready=0.
  - On out_valid & out_ready: acc, cnt and sat clear to 0, out_valid falls, and the state returns to ACC. in_ready=1 on the next cycle; there is no bypass.
  - flush and in_valid are ignored in HOLD.
- Output holding
  - After the handshake, out_sum, out_count and out_sat keep their last values until the next frame end.
- Width and arithmetic
  - The addition is computed at ACC_W+1 bits and then clamped.
  - cnt never exceeds FRAME_LEN.
- Reset mid-operation
  - A partial frame is discarded with no output.
  - A pending HOLD result is dropped and out_valid falls immediately.
- Handshake rules
  - in_ready does not depend on in_valid.
  - out_valid does not depend on out_ready; there are no combinational loops.

Test Plan:
- Decode sweep, FRAME_LEN=1, out_ready=1:
  - (E=0, M=5) -> out_sum=5.
  - (E=1, M=0) -> 16.
  - (E=3, M=10) -> 104.
  - (E=7, M=15) -> 1984.
  - out_count=1 and out_sat=0 each time.
- Full frame, defaults: 16 beats of (E=7, M=15) back-to-back -> out_sum=31744, out_count=16, out_sat=0. out_valid is high on the cycle after the 16th beat.
- Saturation, ACC_W=14: same 16 beats -> out_sum=16383, out_sat=1. The next frame of 2×(E=0, M=1) -> out_sum=2, out_sat=0.
- Flush:
  - Beats 5, 16 and 104, with flush asserted together with the third beat -> out_sum=125, out_count=3.
  - flush alone with cnt=0 -> no output.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum stable, in_ready=0, and in_valid beats are not consumed. Then out_ready=1 -> in_ready=1 the following cycle.
- Reset: assert rst after 7 beats, then after 16 further beats of (E=0, M=1) -> exactly one result with out_sum=16, out_count=16. Asserting rst during HOLD drops out_valid asynchronously.
